// File: rtl/lsu_seq_split.sv
// Sequential load/store unit: one request becomes one or two aligned bus beats.
// Stores are lane-placed with byte strobes; loads are reassembled and extended.
module lsu_seq_split #(
  parameter int BUS_W          = 32,
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_sl_type,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BUS_W-1:0]     mem_wdata,
  output logic [BUS_W/8-1:0]   mem_wstrb,
  input  logic                 mem_rvalid,
  input  logic [BUS_W-1:0]     mem_rdata
);
  localparam int B     = BUS_W / 8;
  localparam int OFF_W = $clog2(B);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [OFF_W-1:0]    off_q;
  logic [1:0]          sz_q;
  logic                uns_q, st_q, cross_q;
  logic [2*B-1:0]      strb_q;
  logic [2*BUS_W-1:0]  wd_q;
  logic [BUS_W-1:0]    lo_q, hi_q;
  logic                mem_req_valid_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [BUS_W-1:0]    mem_wdata_q;
  logic [B-1:0]        mem_wstrb_q;
  logic                resp_valid_q, resp_err_q;
  logic [31:0]         resp_rdata_q;

  function automatic logic [2*B-1:0] place_strb(input logic [1:0] sz, input logic [OFF_W-1:0] off);
    logic [2*B-1:0] m;
    m = '0;
    case (sz)
      2'b01:   m[0]   = 1'b1;
      2'b10:   m[1:0] = 2'b11;
      2'b11:   m[3:0] = 4'hF;
      default: m      = '0;
    endcase
    return m << off;
  endfunction

  function automatic logic [2*BUS_W-1:0] place_data(input logic [1:0] sz, input logic [OFF_W-1:0] off,
                                                    input logic [31:0] wd);
    logic [2*BUS_W-1:0] d;
    d = '0;
    case (sz)
      2'b01:   d[7:0]  = wd[7:0];
      2'b10:   d[15:0] = wd[15:0];
      2'b11:   d[31:0] = wd;
      default: d       = '0;
    endcase
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] load_ext(input logic [2*BUS_W-1:0] cat, input logic [OFF_W-1:0] off,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] sh;
    sh = 32'(cat >> {off, 3'b000});
    case (sz)
      2'b01:   return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b10:   return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      2'b11:   return sh;
      default: return '0;
    endcase
  endfunction

  logic [OFF_W-1:0]  req_off;
  logic [1:0]        req_sz;
  logic [OFF_W:0]    req_n;
  logic              req_illegal, req_misal, req_cross;
  logic [ADDR_W-1:0] req_base;

  assign req_off     = req_addr[OFF_W-1:0];
  assign req_sz      = req_sl_type[1:0];
  assign req_illegal = (req_sz == 2'b00);
  assign req_misal   = ((req_sz == 2'b10) && req_addr[0]) || ((req_sz == 2'b11) && (req_addr[1:0] != 2'b00));
  assign req_cross   = ({1'b0, req_off} + req_n) > (OFF_W+1)'(B);
  assign req_base    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_comb begin
    case (req_sz)
      2'b01:   req_n = (OFF_W+1)'(1);
      2'b10:   req_n = (OFF_W+1)'(2);
      2'b11:   req_n = (OFF_W+1)'(4);
      default: req_n = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      base_q          <= '0;
      off_q           <= '0;
      sz_q            <= '0;
      uns_q           <= 1'b0;
      st_q            <= 1'b0;
      cross_q         <= 1'b0;
      strb_q          <= '0;
      wd_q            <= '0;
      lo_q            <= '0;
      hi_q            <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          base_q  <= req_base;
          off_q   <= req_off;
          sz_q    <= req_sz;
          uns_q   <= req_sl_type[2];
          st_q    <= req_sl_type[3];
          cross_q <= req_cross;
          strb_q  <= place_strb(req_sz, req_off);
          wd_q    <= place_data(req_sz, req_off, req_wdata);
          lo_q    <= '0;
          hi_q    <= '0;
          if (req_illegal || (req_misal && !MISALIGN_SPLIT)) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q         <= REQ0;
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= req_sl_type[3];
            mem_addr_q      <= req_base;
            mem_wstrb_q     <= req_sl_type[3] ? place_strb(req_sz, req_off) >> 0 : '0;
            mem_wdata_q     <= req_sl_type[3] ? place_data(req_sz, req_off, req_wdata) >> 0 : '0;
          end
        end
        REQ0: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          mem_we_q        <= 1'b0;
          mem_wstrb_q     <= '0;
          mem_wdata_q     <= '0;
          if (!st_q) begin
            state_q <= WAIT0;
          end else if (cross_q) begin
            // Second store beat carries the upper half of the placed lanes
            state_q         <= REQ1;
            mem_req_valid_q <= 1'b1;
            mem_we_q        <= 1'b1;
            mem_addr_q      <= base_q + ADDR_W'(B);
            mem_wstrb_q     <= strb_q[2*B-1:B];
            mem_wdata_q     <= wd_q[2*BUS_W-1:BUS_W];
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        WAIT0: if (mem_rvalid) begin
          lo_q <= mem_rdata;
          if (cross_q) begin
            state_q         <= REQ1;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= base_q + ADDR_W'(B);
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_ext({{BUS_W{1'b0}}, mem_rdata}, off_q, sz_q, uns_q);
          end
        end
        REQ1: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          mem_we_q        <= 1'b0;
          mem_wstrb_q     <= '0;
          mem_wdata_q     <= '0;
          if (st_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q <= WAIT1;
          end
        end
        WAIT1: if (mem_rvalid) begin
          hi_q         <= mem_rdata;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= load_ext({mem_rdata, lo_q}, off_q, sz_q, uns_q);
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
endmodule

// File: tb/tb_lsu_seq_split.sv
// Bench for lsu_seq_split: a 32-bit splitting instance driven from a vector table
// and a 64-bit rejecting instance exercised by hand-written sequences.
module tb_lsu_seq_split;
  logic clk, rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit bus, misaligned accesses split
  logic        req_valid, req_ready, resp_valid, resp_err;
  logic [3:0]  req_sl_type;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  // 64-bit bus, misaligned accesses rejected
  logic        req_valid6, req_ready6, resp_valid6, resp_err6;
  logic [3:0]  req_sl_type6;
  logic [31:0] req_addr6, req_wdata6, resp_rdata6;
  logic        mem_req_valid6, mem_req_ready6, mem_we6, mem_rvalid6;
  logic [31:0] mem_addr6;
  logic [63:0] mem_wdata6, mem_rdata6;
  logic [7:0]  mem_wstrb6;

  lsu_seq_split #(.BUS_W(32), .ADDR_W(32), .MISALIGN_SPLIT(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sl_type(req_sl_type),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  lsu_seq_split #(.BUS_W(64), .ADDR_W(32), .MISALIGN_SPLIT(1'b0)) u64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid6), .req_ready(req_ready6), .req_sl_type(req_sl_type6),
    .req_addr(req_addr6), .req_wdata(req_wdata6),
    .resp_valid(resp_valid6), .resp_rdata(resp_rdata6), .resp_err(resp_err6),
    .mem_req_valid(mem_req_valid6), .mem_req_ready(mem_req_ready6), .mem_we(mem_we6),
    .mem_addr(mem_addr6), .mem_wdata(mem_wdata6), .mem_wstrb(mem_wstrb6),
    .mem_rvalid(mem_rvalid6), .mem_rdata(mem_rdata6));

  typedef struct {
    logic [3:0]  sl;
    logic [31:0] addr, wdata, rd0, rd1;
    int          stall, nbeats;
    logic [31:0] a0; logic [3:0] s0; logic [31:0] w0;
    logic [31:0] a1; logic [3:0] s1; logic [31:0] w1;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tv[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run32(input int idx);
    vec_t v;
    int cyc, stl, nb, nrd, lat;
    logic done, rdp, r_err;
    logic [31:0] r_data;
    logic [31:0] ba[2]; logic [3:0] bs[2]; logic [31:0] bw[2]; logic bwe[2];
    v = tv[idx];
    cyc = 0; stl = 0; nb = 0; nrd = 0; lat = 0; done = 1'b0; rdp = 1'b0;
    r_err = 1'b0; r_data = '0;
    for (int k = 0; k < 2; k++) begin ba[k] = '0; bs[k] = '0; bw[k] = '0; bwe[k] = 1'b0; end
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_sl_type = v.sl; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rdp) begin
        mem_rvalid = 1'b1;
        mem_rdata  = (nrd == 0) ? v.rd0 : v.rd1;
        nrd++;
        rdp = 1'b0;
      end
      if (resp_valid) begin
        done = 1'b1; lat = cyc; r_data = resp_rdata; r_err = resp_err;
      end else if (mem_req_valid) begin
        if (stl < v.stall) stl++;
        else begin
          mem_req_ready = 1'b1;
          if (nb < 2) begin ba[nb] = mem_addr; bs[nb] = mem_wstrb; bw[nb] = mem_wdata; bwe[nb] = mem_we; end
          if (!mem_we) rdp = 1'b1;
          nb++;
          stl = 0;
        end
      end
    end
    chk($sformatf("v%0d completed", idx), {63'b0, done}, 64'd1);
    chk($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d beats", idx), 64'(nb), 64'(v.nbeats));
    chk($sformatf("v%0d resp_err", idx), {63'b0, r_err}, {63'b0, v.err});
    chk($sformatf("v%0d resp_rdata", idx), {32'b0, r_data}, {32'b0, v.rdata});
    if (v.nbeats >= 1)
      chk($sformatf("v%0d beat0", idx), {bwe[0], ba[0], bs[0], bw[0]}, {v.sl[3], v.a0, v.s0, v.w0});
    if (v.nbeats >= 2)
      chk($sformatf("v%0d beat1", idx), {bwe[1], ba[1], bs[1], bw[1]}, {v.sl[3], v.a1, v.s1, v.w1});
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_sl_type = 0; req_addr = 0; req_wdata = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    req_valid6 = 0; req_sl_type6 = 0; req_addr6 = 0; req_wdata6 = 0;
    mem_req_ready6 = 0; mem_rvalid6 = 0; mem_rdata6 = 0;

    //            sl       addr          wdata         rd0           rd1          stl nb a0            s0     w0            a1            s1     w1            rdata         err lat
    tv.push_back('{4'b1011, 32'h100,      32'hDEADBEEF, 32'h0,        32'h0,        0, 1, 32'h100,      4'hF, 32'hDEADBEEF, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2});
    tv.push_back('{4'b0001, 32'h103,      32'h0,        32'h80FF0000, 32'h0,        0, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 0, 3});
    tv.push_back('{4'b0101, 32'h103,      32'h0,        32'h80FF0000, 32'h0,        0, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00000080, 0, 3});
    tv.push_back('{4'b1011, 32'h102,      32'h11223344, 32'h0,        32'h0,        0, 2, 32'h100,      4'hC, 32'h33440000, 32'h104,      4'h3, 32'h00001122, 32'h0,        0, 3});
    tv.push_back('{4'b0010, 32'h107,      32'h0,        32'hAB000000, 32'h000000CD, 2, 2, 32'h104,      4'h0, 32'h0,        32'h108,      4'h0, 32'h0,        32'hFFFFCDAB, 0, 9});
    tv.push_back('{4'b0110, 32'h107,      32'h0,        32'hAB000000, 32'h000000CD, 2, 2, 32'h104,      4'h0, 32'h0,        32'h108,      4'h0, 32'h0,        32'h0000CDAB, 0, 9});
    tv.push_back('{4'b0000, 32'h100,      32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0,        1, 1});
    tv.push_back('{4'b1001, 32'h101,      32'hFFFFFFA5, 32'h0,        32'h0,        0, 1, 32'h100,      4'h2, 32'h0000A500, 32'h0,        4'h0, 32'h0,        32'h0,        0, 2});
    tv.push_back('{4'b1010, 32'h103,      32'h0000BEEF, 32'h0,        32'h0,        0, 2, 32'h100,      4'h8, 32'hEF000000, 32'h104,      4'h1, 32'h000000BE, 32'h0,        0, 3});
    tv.push_back('{4'b0010, 32'h101,      32'h0,        32'h00FACE00, 32'h0,        0, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFACE, 0, 3});
    tv.push_back('{4'b0011, 32'h102,      32'h0,        32'h33440000, 32'h00001122, 0, 2, 32'h100,      4'h0, 32'h0,        32'h104,      4'h0, 32'h0,        32'h11223344, 0, 5});
    tv.push_back('{4'b0011, 32'hFFFFFFFE, 32'h0,        32'hBEEF0000, 32'h0000DEAD, 0, 2, 32'hFFFFFFFC, 4'h0, 32'h0,        32'h00000000, 4'h0, 32'h0,        32'hDEADBEEF, 0, 5});
    tv.push_back('{4'b0001, 32'h100,      32'h0,        32'h1234567F, 32'h0,        0, 1, 32'h100,      4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0000007F, 0, 3});
    tv.push_back('{4'b1011, 32'h104,      32'hCAFEF00D, 32'h0,        32'h0,        1, 1, 32'h104,      4'hF, 32'hCAFEF00D, 32'h0,        4'h0, 32'h0,        32'h0,        0, 3});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst req_ready", {63'b0, req_ready}, 64'd1);
    chk("rst mem ctl", {61'b0, mem_req_valid, mem_we, resp_valid}, 64'd0);
    chk("rst mem addr/strb/data", {mem_addr, mem_wstrb, mem_wdata}, '0);
    chk("rst resp", {31'b0, resp_err, resp_rdata}, 64'd0);
    chk("rst64 outputs", {req_ready6, mem_req_valid6, mem_we6, resp_valid6, resp_err6, mem_wstrb6}, {1'b1, 12'b0});

    for (int i = 0; i < tv.size(); i++) run32(i);

    // 64-bit instance: misaligned word rejected without bus activity
    @(negedge clk);
    req_valid6 = 1'b1; req_sl_type6 = 4'b0011; req_addr6 = 32'h101;
    @(negedge clk);
    req_valid6 = 1'b0;
    chk("err64 resp_valid", {63'b0, resp_valid6}, 64'd1);
    chk("err64 resp_err", {63'b0, resp_err6}, 64'd1);
    chk("err64 resp_rdata", {32'b0, resp_rdata6}, 64'd0);
    chk("err64 no bus", {63'b0, mem_req_valid6}, 64'd0);
    @(negedge clk);
    chk("err64 pulse ends", {62'b0, resp_valid6, mem_req_valid6}, 64'd0);

    // 64-bit instance: word at offset 4 stays in one beat
    req_valid6 = 1'b1; req_sl_type6 = 4'b0011; req_addr6 = 32'h10C;
    @(negedge clk);
    req_valid6 = 1'b0;
    chk("lw64 beat", {mem_req_valid6, mem_we6, mem_addr6, mem_wstrb6}, {1'b1, 1'b0, 32'h108, 8'h00});
    mem_req_ready6 = 1'b1;
    @(negedge clk);
    mem_req_ready6 = 1'b0;
    chk("lw64 single beat", {63'b0, mem_req_valid6}, 64'd0);
    mem_rvalid6 = 1'b1; mem_rdata6 = 64'h12345678_00000000;
    @(negedge clk);
    mem_rvalid6 = 1'b0;
    chk("lw64 resp", {resp_valid6, resp_err6, resp_rdata6}, {1'b1, 1'b0, 32'h12345678});

    // Reset while waiting for read data; a late rvalid must be ignored
    @(negedge clk);
    req_valid6 = 1'b1; req_sl_type6 = 4'b0011; req_addr6 = 32'h10C;
    @(negedge clk);
    req_valid6 = 1'b0; mem_req_ready6 = 1'b1;
    @(negedge clk);
    mem_req_ready6 = 1'b0;
    chk("rst64 in WAIT0", {63'b0, req_ready6}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst64 async ctl", {req_ready6, mem_req_valid6, mem_we6, resp_valid6, resp_err6}, {1'b1, 4'b0});
    chk("rst64 async data", {mem_addr6, mem_wstrb6, resp_rdata6}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid6 = 1'b1; mem_rdata6 = 64'hFFFFFFFF_FFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid6 = 1'b0;
      chk($sformatf("late rvalid c%0d", c), {61'b0, resp_valid6, mem_req_valid6, req_ready6}, 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
